// File: rtl/final_sum_serial_78_if.sv
`default_nettype none
// ============================================================================
// Module   : final_sum_serial_78_if
// Purpose  : Handshake and data bundle for the serial 3-operand final adder.
//            The master drives operands and consumes the result; the slave
//            (the adder) accepts operands and presents the result.
// Signals  : in_valid/in_ready       operand handshake
//            res_0..res_2 [2*RADIX]  aligned group sums
//            out_valid/out_ready     result handshake
//            prod_lo/prod_hi [RADIX] sum bits, low and high limb
//            carry_out [2]           sum bits above 2*RADIX (0..2)
//            busy                    adder is in ADD or DONE
// Revision : 1.0 - initial release
// ============================================================================
interface final_sum_serial_78_if #(
  parameter int RADIX = 78
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*RADIX-1:0]   res_0;
  logic [2*RADIX-1:0]   res_1;
  logic [2*RADIX-1:0]   res_2;
  logic                 out_valid;
  logic                 out_ready;
  logic [RADIX-1:0]     prod_lo;
  logic [RADIX-1:0]     prod_hi;
  logic [1:0]           carry_out;
  logic                 busy;

  modport master (
    output in_valid, res_0, res_1, res_2, out_ready,
    input  in_ready, out_valid, prod_lo, prod_hi, carry_out, busy
  );

  modport slave (
    input  in_valid, res_0, res_1, res_2, out_ready,
    output in_ready, out_valid, prod_lo, prod_hi, carry_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/final_sum_serial_78.sv
`default_nettype none
// ============================================================================
// Module   : final_sum_serial_78
// Purpose  : Final reduction of three aligned 2*RADIX-bit group sums into the
//            product. The 3-operand addition is folded over CHUNK-bit slices,
//            one slice per clock, with a 2-bit inter-slice carry.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset
//            bus    final_sum_serial_78_if.slave (operands, result, handshakes)
//                   The interface RADIX must equal this module's RADIX.
// Revision : 1.0 - initial release
// ============================================================================
module final_sum_serial_78 #(
  parameter int RADIX = 78,
  parameter int CHUNK = 26
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  final_sum_serial_78_if.slave  bus
);

  localparam int W      = 2 * RADIX;
  localparam int NCHUNK = W / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK + 1) : 1;

  // The slicing only makes sense when the slices tile the operand exactly.
  generate
    if ((W % CHUNK) != 0) begin : g_bad_chunk
      $error("final_sum_serial_78: 2*RADIX must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [W-1:0]       r_op0;
  logic [W-1:0]       r_op1;
  logic [W-1:0]       r_op2;
  logic [W-1:0]       r_res;
  logic [1:0]         r_carry;
  logic [1:0]         r_cout;
  logic [IDXW-1:0]    r_idx;

  logic [CHUNK-1:0]   w_a0;
  logic [CHUNK-1:0]   w_a1;
  logic [CHUNK-1:0]   w_a2;
  logic [CHUNK+1:0]   w_sum;
  logic               w_last;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_ADD;
      ST_ADD:  if (w_last)        w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs depend on the state only, so reset drives them at once.
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_ADD) || (r_state == ST_DONE);

  assign bus.prod_lo   = r_res[RADIX-1:0];
  assign bus.prod_hi   = r_res[W-1:RADIX];
  assign bus.carry_out = r_cout;

  assign w_last = (r_idx == IDXW'(NCHUNK - 1));

  // ---------------------------------------------------------------------------
  // Slice selection: a compare per slice keeps every part-select constant.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_a0 = '0;
    w_a1 = '0;
    w_a2 = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a0 = r_op0[k*CHUNK +: CHUNK];
        w_a1 = r_op1[k*CHUNK +: CHUNK];
        w_a2 = r_op2[k*CHUNK +: CHUNK];
      end
    end
  end

  // Three CHUNK-bit slices plus a carry of at most 2 fit in CHUNK+2 bits,
  // and the carry out of that sum is again at most 2.
  assign w_sum = {2'b00, w_a0} + {2'b00, w_a1} + {2'b00, w_a2}
               + {{CHUNK{1'b0}}, r_carry};

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op0   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_res   <= '0;
      r_carry <= '0;
      r_cout  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op0   <= bus.res_0;
            r_op1   <= bus.res_1;
            r_op2   <= bus.res_2;
            r_carry <= '0;
            r_idx   <= '0;
          end
        end
        ST_ADD: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDXW'(k)) begin
              r_res[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            end
          end
          r_carry <= w_sum[CHUNK+1:CHUNK];
          r_idx   <= r_idx + IDXW'(1);
          // carry_out only changes once the whole sum is known.
          if (w_last) begin
            r_cout <= w_sum[CHUNK+1:CHUNK];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_final_sum_serial_78.sv
`default_nettype none
// ============================================================================
// Module   : tb_final_sum_serial_78
// Purpose  : Directed, scoreboard-checked bench for final_sum_serial_78.
// Revision : 1.0 - initial release
// ============================================================================
module tb_final_sum_serial_78;

  localparam int RADIX = 78;
  localparam int W     = 2 * RADIX;

  typedef struct packed {
    logic [RADIX-1:0] lo;
    logic [RADIX-1:0] hi;
    logic [1:0]       c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  final_sum_serial_78_if #(.RADIX(RADIX)) itf ();

  final_sum_serial_78 #(.RADIX(RADIX), .CHUNK(26)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (itf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, required event did not occur", nm);
  endtask

  // Monitor: compares the presented result against the scoreboard head
  // every cycle out_valid is high, and retires it on the handshake.
  always @(negedge clk) begin
    if (mon_en && rst_n && itf.out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got lo=%0h hi=%0h c=%0d expected none",
                 itf.prod_lo, itf.prod_hi, itf.carry_out);
      end else begin
        mon_e = sb_q[0];
        total++;
        if ({itf.prod_lo, itf.prod_hi, itf.carry_out} !== mon_e) begin
          bad++;
          $display("FAIL result: got lo=%0h hi=%0h c=%0d expected lo=%0h hi=%0h c=%0d",
                   itf.prod_lo, itf.prod_hi, itf.carry_out, mon_e.lo, mon_e.hi, mon_e.c);
        end
        if (itf.out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!itf.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!itf.in_ready) timeout_fail("wait_idle");
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!itf.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!itf.out_valid) timeout_fail("wait_out_valid");
  endtask

  // Issue one operation with out_ready held high and check exact latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [RADIX-1:0] lo, input logic [RADIX-1:0] hi,
                        input logic [1:0] co);
    wait_idle();
    itf.res_0    = a;
    itf.res_1    = b;
    itf.res_2    = c;
    itf.in_valid = 1'b1;
    sb_q.push_back('{lo: lo, hi: hi, c: co});
    @(posedge clk); #1;                       // E0
    itf.in_valid = 1'b0;
    // Operands must already be latched; disturb the inputs during ADD.
    itf.res_0 = '1;
    itf.res_1 = '1;
    itf.res_2 = '1;
    chk("busy_after_accept", itf.busy, 1);
    chk("in_ready_in_add", itf.in_ready, 0);
    repeat (5) begin                          // E1..E5
      @(posedge clk); #1;
      chk("no_early_valid", itf.out_valid, 0);
      chk("busy_in_add", itf.busy, 1);
    end
    @(posedge clk); #1;                       // E6
    chk("valid_after_E6", itf.out_valid, 1);
    @(posedge clk); #1;                       // handshake edge
    chk("busy_after_done", itf.busy, 0);
    chk("in_ready_after_done", itf.in_ready, 1);
  endtask

  initial begin
    rst_n         = 1'b1;
    itf.in_valid  = 1'b0;
    itf.out_ready = 1'b1;
    itf.res_0     = '0;
    itf.res_1     = '0;
    itf.res_2     = '0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", itf.in_ready, 1);
    chk("rst_out_valid", itf.out_valid, 0);
    chk("rst_busy", itf.busy, 0);
    chk("rst_prod_lo", itf.prod_lo, 0);
    chk("rst_prod_hi", itf.prod_hi, 0);
    chk("rst_carry_out", itf.carry_out, 0);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Small operands.
    run_op(156'd1, 156'd2, 156'd3, 78'd6, 78'd0, 2'd0);
    // Carry ripples through every slice.
    run_op({W{1'b1}}, 156'd1, 156'd0, 78'd0, 78'd0, 2'd1);
    // Maximum operands: 3*(2^156-1) = 2*2^156 + (2^156-3).
    run_op({W{1'b1}}, {W{1'b1}}, {W{1'b1}}, {RADIX{1'b1}} - 78'd2, {RADIX{1'b1}}, 2'd2);
    // Carry across the lo/hi limb boundary: (2^78-1)+1+2^77 = 2^78+2^77.
    run_op({78'd0, {RADIX{1'b1}}}, 156'd1, {78'd0, 1'b1, 77'd0},
           {1'b1, 77'd0}, 78'd1, 2'd0);

    // Backpressure with new operands waiting.
    wait_idle();
    itf.out_ready = 1'b0;
    itf.res_0     = {78'd1, 78'd5};
    itf.res_1     = {78'd2, 78'd10};
    itf.res_2     = {78'd3, 78'd20};
    itf.in_valid  = 1'b1;
    sb_q.push_back('{lo: 78'd35, hi: 78'd6, c: 2'd0});
    @(posedge clk); #1;
    itf.res_0 = 156'd100;
    itf.res_1 = 156'd200;
    itf.res_2 = 156'd300;
    sb_q.push_back('{lo: 78'd600, hi: 78'd0, c: 2'd0});
    wait_out_valid();
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_out_valid", itf.out_valid, 1);
      chk("stall_in_ready", itf.in_ready, 0);
    end
    itf.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", itf.in_ready, 1);
    chk("release_out_valid", itf.out_valid, 0);
    @(posedge clk); #1;
    chk("second_capture", itf.busy, 1);
    itf.in_valid = 1'b0;
    wait_out_valid();
    @(posedge clk); #1;
    chk("second_done_idle", itf.in_ready, 1);

    // Reset during ADD: the aborted operation must never be presented.
    wait_idle();
    itf.res_0    = 156'd5;
    itf.res_1    = 156'd5;
    itf.res_2    = 156'd5;
    itf.in_valid = 1'b1;
    @(posedge clk); #1;                       // E0
    itf.in_valid = 1'b0;
    repeat (3) @(posedge clk);                // E1..E3
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", itf.in_ready, 1);
    chk("abort_busy", itf.busy, 0);
    chk("abort_out_valid", itf.out_valid, 0);
    chk("abort_prod_lo", itf.prod_lo, 0);
    chk("abort_carry_out", itf.carry_out, 0);
    #2 rst_n = 1'b1;
    run_op(156'd7, 156'd8, 156'd9, 78'd24, 78'd0, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/final_sum_serial_78.md
Name: final_sum_serial_78

Overview:
- Downstream stage of the 15-way partial-product adder. It consumes the three 156-bit group sums res_0/res_1/res_2 and reduces them to the final 2*RADIX-bit product.
- The three inputs are already aligned in a common bit frame, so the product is res_0+res_1+res_2.
- A full-width 3-operand carry-propagate adder would be timing-critical, so this block folds the addition over CHUNK-bit slices, one slice per cycle, with a 2-bit carry.
- Valid/ready handshake on both sides.

Parameters:
RADIX, 78, limb width; operands and sum are 2*RADIX bits
CHUNK, 26, slice width added per cycle; 2*RADIX must be an exact multiple of CHUNK (elaboration error otherwise)
NCHUNK, 2*RADIX/CHUNK (=6), derived localparam, cycles per addition

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  res_0..res_2 valid
in_ready  output  1  block can accept operands
res_0  input  2*RADIX  group sum 0
res_1  input  2*RADIX  group sum 1
res_2  input  2*RADIX  group sum 2
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
prod_lo  output  RADIX  sum bits [RADIX-1:0]
prod_hi  output  RADIX  sum bits [2*RADIX-1:RADIX]
carry_out  output  2  sum bits [2*RADIX+1:2*RADIX], value 0..2
busy  output  1  high in ADD or DONE

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n), as already decided. On rst_n=0, immediately: state=IDLE; operand, result and carry registers cleared; idx=0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, prod_lo=0, prod_hi=0, carry_out=0.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture res_0..res_2 into operand registers, carry=0, idx=0, go to ADD.
- State ADD:
  - in_ready=0, and in_valid is ignored.
  - Each edge computes s = r0[idx] + r1[idx] + r2[idx] + carry (CHUNK+2 bits), where rK[idx] is bits [idx*CHUNK +: CHUNK].
  - Write s[CHUNK-1:0] to the result slice idx; carry = s[CHUNK+1:CHUNK]; idx++.
  - The carry never exceeds 2, since 3*(2^CHUNK-1)+2 < 3*2^CHUNK.
  - On the edge processing idx=NCHUNK-1, go to DONE; carry_out takes the final carry.
- State DONE:
  - out_valid=1.
  - prod_lo, prod_hi and carry_out are stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE. The result registers hold their last value, but the consumer must qualify them with out_valid.
- Latency:
  - Accepting edge E0; slices are processed on edges E1..E6.
  - out_valid is high in the cycle after E6.
  - Minimum initiation interval is NCHUNK+2 = 8 cycles; there is no overlap of consecutive operations.
- Arithmetic:
  - Unsigned; the result is exact mod 2^(2*RADIX+2).
  - No saturation; overflow beyond 156 bits appears only on carry_out.
- Boundaries:
  - in_valid held high through ADD/DONE does not cause a second capture. The next capture happens only once the block is back in IDLE.
  - out_ready high before DONE has no effect.
  - Simultaneous out_ready=1 in DONE and in_valid=1: the block returns to IDLE first; the operands are captured on the following edge.
  - Operand registers are not modified during ADD, even if the res_* inputs change.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge -> in_ready=1, out_valid=0, busy=0, prod_lo=prod_hi=0, carry_out=0 immediately.
- Small operands: res_0=1, res_1=2, res_2=3 -> out_valid in the cycle after E6; prod_lo=6, prod_hi=0, carry_out=0; busy high from E0 to DONE exit.
- Cross-slice carry: res_0=2^156-1, res_1=1, res_2=0 -> prod_lo=0, prod_hi=0, carry_out=1.
- Maximum: res_0=res_1=res_2=2^156-1 -> prod_lo=2^78-3, prod_hi=2^78-1, carry_out=2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data.
  - During the stall: outputs stay unchanged, in_ready=0, and the new data is not captured.
  - Raise out_ready: back to IDLE, then the new data is accepted on the next edge and its result is correct.
- Reset during ADD: pulse rst_n low after E3 -> all outputs 0 and state IDLE at once; after release, a fresh operation (7, 8, 9) gives prod_lo=24 with no residue from the aborted operation.
